block_expander: RTL and testbench

BLOCK_EXPANDER -- requirements
Module: block_expander

---
 rtl/block_expander.sv | 197 +++++++++++++++++++
 tb/tb_block_expander.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_expander.sv
`default_nettype none
// ============================================================================
//  Package     : mure_pkg
//  Description : Field widths shared by the trace-decode blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mure_pkg;
    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 6;
    localparam int ITYPE_LEN   = 4;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;
endpackage

// ============================================================================
//  Module      : block_expander
//  Description : Expands a retired-instruction block (count of retired
//                halfwords plus first address) into up to NRET individual
//                instructions per cycle, using a same-cycle instruction-size
//                lookup, then signals a block-completion event.
//  Ports       : clk_i / rst_i            clock, synchronous active-high reset
//                valid_i / ready_o        block handshake
//                iretire_i .. iaddr_i     block fields
//                qaddr_o / qcompressed_i  instruction-size lookup
//                valid_o .. priv_o        per-slot reconstructed instructions
//                evt_*_o                  block-completion event
//                err_o                    sticky size-mismatch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module block_expander
    import mure_pkg::*;
#(
    parameter int NRET = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [IRETIRE_LEN-1:0]             iretire_i,
    input  logic                               ilastsize_i,
    input  logic [ITYPE_LEN-1:0]               itype_i,
    input  logic [CAUSE_LEN-1:0]               cause_i,
    input  logic [XLEN-1:0]                    tval_i,
    input  logic [PRIV_LEN-1:0]                priv_i,
    input  logic [XLEN-1:0]                    iaddr_i,
    output logic [NRET-1:0][XLEN-1:0]          qaddr_o,
    input  logic [NRET-1:0]                    qcompressed_i,
    output logic [NRET-1:0]                    valid_o,
    output logic [NRET-1:0][XLEN-1:0]          pc_o,
    output logic [NRET-1:0]                    compressed_o,
    output logic [NRET-1:0][ITYPE_LEN-1:0]     itype_o,
    output logic [NRET-1:0][PRIV_LEN-1:0]      priv_o,
    output logic                               evt_valid_o,
    output logic [ITYPE_LEN-1:0]               evt_itype_o,
    output logic [CAUSE_LEN-1:0]               evt_cause_o,
    output logic [XLEN-1:0]                    evt_tval_o,
    output logic [PRIV_LEN-1:0]                evt_priv_o,
    output logic [XLEN-1:0]                    evt_iaddr_o,
    output logic                               err_o
);

    // Halfword counts are carried one bit wider so a 32-bit instruction that
    // overshoots the remaining count cannot wrap around.
    localparam int UW = IRETIRE_LEN + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EVENT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IRETIRE_LEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic                    err_q, err_d;
    logic                    ilastsize_q;
    logic [ITYPE_LEN-1:0]    itype_q;
    logic [CAUSE_LEN-1:0]    cause_q;
    logic [XLEN-1:0]         tval_q;
    logic [PRIV_LEN-1:0]     priv_q;
    logic [XLEN-1:0]         iaddr_q;

    logic [XLEN-1:0]         qaddr_w [NRET+1];
    logic [UW-1:0]           used_w  [NRET+1];
    logic [NRET-1:0]         slot_valid_w;
    logic [NRET-1:0]         slot_last_w;
    logic                    any_last_w;
    logic                    mismatch_w;
    logic                    accept_w;
    logic                    in_expand_w;

    assign ready_o     = (state_q == IDLE) && !rst_i;
    assign accept_w    = valid_i && ready_o;
    assign in_expand_w = (state_q == EXPAND);
    assign err_o       = err_q;

    // Per-slot address/halfword chain driven by the lookup answers.
    always_comb begin
        qaddr_w[0]   = pc_q;
        used_w[0]    = '0;
        slot_valid_w = '0;
        slot_last_w  = '0;
        any_last_w   = 1'b0;
        mismatch_w   = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            qaddr_w[k+1] = qaddr_w[k] + (qcompressed_i[k] ? XLEN'(2) : XLEN'(4));
            used_w[k+1]  = used_w[k] + (qcompressed_i[k] ? UW'(1) : UW'(2));
            slot_valid_w[k] = in_expand_w && !any_last_w &&
                              (used_w[k] < {1'b0, rem_q});
            slot_last_w[k]  = slot_valid_w[k] && (used_w[k+1] >= {1'b0, rem_q});
            if (slot_last_w[k]) begin
                // The final instruction must land exactly on the count and
                // agree in size with the reported last-instruction size.
                mismatch_w = (used_w[k+1] != {1'b0, rem_q}) ||
                             (qcompressed_i[k] != !ilastsize_q);
            end
            any_last_w = any_last_w | slot_last_w[k];
        end
    end

    // Slot and event outputs; everything not valid is forced to zero.
    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            qaddr_o[k]      = in_expand_w ? qaddr_w[k] : '0;
            valid_o[k]      = slot_valid_w[k];
            pc_o[k]         = slot_valid_w[k] ? qaddr_w[k] : '0;
            compressed_o[k] = slot_valid_w[k] & qcompressed_i[k];
            itype_o[k]      = slot_last_w[k] ? itype_q : '0;
            priv_o[k]       = slot_valid_w[k] ? priv_q : '0;
        end
        evt_valid_o = (state_q == EVENT) || any_last_w;
        evt_itype_o = evt_valid_o ? itype_q : '0;
        evt_cause_o = evt_valid_o ? cause_q : '0;
        evt_tval_o  = evt_valid_o ? tval_q  : '0;
        evt_priv_o  = evt_valid_o ? priv_q  : '0;
        evt_iaddr_o = evt_valid_o ? iaddr_q : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    state_d = (iretire_i != '0) ? EXPAND : EVENT;
                    rem_d   = iretire_i;
                    pc_d    = iaddr_i;
                end
            end
            EXPAND: begin
                if (any_last_w) begin
                    state_d = IDLE;
                    err_d   = err_q | mismatch_w;
                end else begin
                    // No slot finished the block, so used_NRET < rem_q here.
                    rem_d = rem_q - used_w[NRET][IRETIRE_LEN-1:0];
                    pc_d  = qaddr_w[NRET];
                end
            end
            EVENT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            pc_q        <= '0;
            err_q       <= 1'b0;
            ilastsize_q <= 1'b0;
            itype_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_q      <= '0;
            iaddr_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            if (accept_w) begin
                ilastsize_q <= ilastsize_i;
                itype_q     <= itype_i;
                cause_q     <= cause_i;
                tval_q      <= tval_i;
                priv_q      <= priv_i;
                iaddr_q     <= iaddr_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_expander
//  Description : Directed self-checking bench for block_expander (NRET = 2).
//                The instruction-size lookup answers "compressed" only for
//                the address held in comp_a.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_expander;
    import mure_pkg::*;

    localparam int NRET = 2;

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic                           valid_i;
    logic                           ready_o;
    logic [IRETIRE_LEN-1:0]         iretire_i;
    logic                           ilastsize_i;
    logic [ITYPE_LEN-1:0]           itype_i;
    logic [CAUSE_LEN-1:0]           cause_i;
    logic [XLEN-1:0]                tval_i;
    logic [PRIV_LEN-1:0]            priv_i;
    logic [XLEN-1:0]                iaddr_i;
    logic [NRET-1:0][XLEN-1:0]      qaddr_o;
    logic [NRET-1:0]                qcompressed_i;
    logic [NRET-1:0]                valid_o;
    logic [NRET-1:0][XLEN-1:0]      pc_o;
    logic [NRET-1:0]                compressed_o;
    logic [NRET-1:0][ITYPE_LEN-1:0] itype_o;
    logic [NRET-1:0][PRIV_LEN-1:0]  priv_o;
    logic                           evt_valid_o;
    logic [ITYPE_LEN-1:0]           evt_itype_o;
    logic [CAUSE_LEN-1:0]           evt_cause_o;
    logic [XLEN-1:0]                evt_tval_o;
    logic [PRIV_LEN-1:0]            evt_priv_o;
    logic [XLEN-1:0]                evt_iaddr_o;
    logic                           err_o;

    logic [XLEN-1:0]                comp_a;
    int                             n_checks = 0;
    int                             n_fail   = 0;

    always #5 clk_i = ~clk_i;

    assign qcompressed_i[0] = (qaddr_o[0] == comp_a);
    assign qcompressed_i[1] = (qaddr_o[1] == comp_a);

    block_expander #(.NRET(NRET)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .iretire_i     (iretire_i),
        .ilastsize_i   (ilastsize_i),
        .itype_i       (itype_i),
        .cause_i       (cause_i),
        .tval_i        (tval_i),
        .priv_i        (priv_i),
        .iaddr_i       (iaddr_i),
        .qaddr_o       (qaddr_o),
        .qcompressed_i (qcompressed_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .compressed_o  (compressed_o),
        .itype_o       (itype_o),
        .priv_o        (priv_o),
        .evt_valid_o   (evt_valid_o),
        .evt_itype_o   (evt_itype_o),
        .evt_cause_o   (evt_cause_o),
        .evt_tval_o    (evt_tval_o),
        .evt_priv_o    (evt_priv_o),
        .evt_iaddr_o   (evt_iaddr_o),
        .err_o         (err_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [IRETIRE_LEN-1:0] ir, input logic ils,
                           input logic [XLEN-1:0] addr, input logic [ITYPE_LEN-1:0] ity,
                           input logic [CAUSE_LEN-1:0] cau, input logic [XLEN-1:0] tv,
                           input logic [PRIV_LEN-1:0] pr);
        valid_i     = 1'b1;
        iretire_i   = ir;
        ilastsize_i = ils;
        iaddr_i     = addr;
        itype_i     = ity;
        cause_i     = cau;
        tval_i      = tv;
        priv_i      = pr;
    endtask

    initial begin
        rst_i   = 1'b1;
        comp_a  = 32'hFFFF_FFF0;
        present('0, 1'b0, '0, '0, '0, '0, '0);
        valid_i = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_ready",  64'(ready_o), 64'd0);
        chk("rst_valid",  64'(valid_o), 64'd0);
        chk("rst_evt",    64'(evt_valid_o), 64'd0);
        chk("rst_err",    64'(err_o), 64'd0);
        chk("rst_qaddr0", 64'(qaddr_o[0]), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("idle_ready", 64'(ready_o), 64'd1);

        // Six halfwords of 32-bit instructions: two expand cycles
        present(6'd6, 1'b1, 32'h1000, 4'd4, 5'd0, 32'd0, 2'd3);
        step();
        valid_i = 1'b0;
        chk("b1c1_valid", 64'(valid_o), 64'h3);
        chk("b1c1_pc0",   64'(pc_o[0]), 64'h1000);
        chk("b1c1_pc1",   64'(pc_o[1]), 64'h1004);
        chk("b1c1_ity1",  64'(itype_o[1]), 64'd0);
        chk("b1c1_priv0", 64'(priv_o[0]), 64'd3);
        chk("b1c1_evt",   64'(evt_valid_o), 64'd0);
        chk("b1c1_ready", 64'(ready_o), 64'd0);
        step();
        chk("b1c2_valid", 64'(valid_o), 64'h1);
        chk("b1c2_pc0",   64'(pc_o[0]), 64'h1008);
        chk("b1c2_ity0",  64'(itype_o[0]), 64'd4);
        chk("b1c2_pc1",   64'(pc_o[1]), 64'd0);
        chk("b1c2_evt",   64'(evt_valid_o), 64'd1);
        chk("b1c2_eity",  64'(evt_itype_o), 64'd4);
        chk("b1c2_eaddr", 64'(evt_iaddr_o), 64'h1000);
        step();
        chk("b1c3_ready", 64'(ready_o), 64'd1);
        chk("b1c3_err",   64'(err_o), 64'd0);
        chk("b1c3_evt",   64'(evt_valid_o), 64'd0);

        // Compressed instruction followed by a 32-bit one
        comp_a = 32'h2000;
        present(6'd3, 1'b1, 32'h2000, 4'd2, 5'd0, 32'd0, 2'd1);
        step();
        valid_i = 1'b0;
        chk("b2_valid", 64'(valid_o), 64'h3);
        chk("b2_comp",  64'(compressed_o), 64'h1);
        chk("b2_pc1",   64'(pc_o[1]), 64'h2002);
        chk("b2_ity0",  64'(itype_o[0]), 64'd0);
        chk("b2_ity1",  64'(itype_o[1]), 64'd2);
        chk("b2_evt",   64'(evt_valid_o), 64'd1);
        step();
        chk("b2_ready", 64'(ready_o), 64'd1);
        chk("b2_err",   64'(err_o), 64'd0);
        comp_a = 32'hFFFF_FFF0;

        // Empty block: only the event cycle
        present(6'd0, 1'b0, 32'h3000, 4'd1, 5'd2, 32'hdead, 2'd0);
        step();
        valid_i = 1'b0;
        chk("b3_evt",   64'(evt_valid_o), 64'd1);
        chk("b3_cause", 64'(evt_cause_o), 64'd2);
        chk("b3_tval",  64'(evt_tval_o), 64'hdead);
        chk("b3_ity",   64'(evt_itype_o), 64'd1);
        chk("b3_valid", 64'(valid_o), 64'd0);
        step();
        chk("b3_ready", 64'(ready_o), 64'd1);
        chk("b3_evt2",  64'(evt_valid_o), 64'd0);

        // Odd halfword count with only 32-bit instructions: size mismatch
        present(6'd3, 1'b1, 32'h3000, 4'd6, 5'd0, 32'd0, 2'd0);
        step();
        valid_i = 1'b0;
        chk("b4_valid", 64'(valid_o), 64'h3);
        chk("b4_ity1",  64'(itype_o[1]), 64'd6);
        chk("b4_evt",   64'(evt_valid_o), 64'd1);
        step();
        chk("b4_err",   64'(err_o), 64'd1);
        chk("b4_ready", 64'(ready_o), 64'd1);

        // Back-to-back blocks with valid_i held high
        present(6'd4, 1'b1, 32'h4000, 4'd3, 5'd1, 32'h11, 2'd1);
        step();
        present(6'd2, 1'b1, 32'h5000, 4'd5, 5'd7, 32'h22, 2'd2);
        chk("b5a_ready", 64'(ready_o), 64'd0);
        chk("b5a_valid", 64'(valid_o), 64'h3);
        chk("b5a_pc1",   64'(pc_o[1]), 64'h4004);
        chk("b5a_eaddr", 64'(evt_iaddr_o), 64'h4000);
        chk("b5a_eity",  64'(evt_itype_o), 64'd3);
        chk("b5a_ecaus", 64'(evt_cause_o), 64'd1);
        step();
        chk("b5_gap_ready", 64'(ready_o), 64'd1);
        chk("b5_gap_valid", 64'(valid_o), 64'd0);
        step();
        valid_i = 1'b0;
        chk("b5b_valid", 64'(valid_o), 64'h1);
        chk("b5b_pc0",   64'(pc_o[0]), 64'h5000);
        chk("b5b_ity0",  64'(itype_o[0]), 64'd5);
        chk("b5b_priv0", 64'(priv_o[0]), 64'd2);
        chk("b5b_eaddr", 64'(evt_iaddr_o), 64'h5000);
        chk("b5b_ecaus", 64'(evt_cause_o), 64'd7);
        chk("b5b_etval", 64'(evt_tval_o), 64'h22);
        step();
        chk("b5_err_sticky", 64'(err_o), 64'd1);

        // Reset in the first expand cycle abandons the block
        present(6'd6, 1'b1, 32'h1000, 4'd4, 5'd0, 32'd0, 2'd3);
        step();
        valid_i = 1'b0;
        rst_i   = 1'b1;
        chk("b6_evt_pre", 64'(evt_valid_o), 64'd0);
        step();
        chk("b6_valid", 64'(valid_o), 64'd0);
        chk("b6_evt",   64'(evt_valid_o), 64'd0);
        chk("b6_err",   64'(err_o), 64'd0);
        chk("b6_pc0",   64'(pc_o[0]), 64'd0);
        chk("b6_qaddr", 64'(qaddr_o[1]), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("b6_ready", 64'(ready_o), 64'd1);
        step();
        chk("b6_idle_evt",   64'(evt_valid_o), 64'd0);
        chk("b6_idle_valid", 64'(valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
